// File: rtl/pulse_capture.sv
// pulse_capture: measures high time and period of a synchronised pad input; results leave on valid/ready.
// Define CAPTURE_FILTER_EN to insert a FILT_LEN-cycle glitch filter between synchroniser and polarity XOR.
module pulse_capture #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             sig_in,
   input  logic             arm,
   input  logic             pol,
   input  logic             cont,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             overflow
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_RISE,
      S_MEAS_HIGH,
      S_MEAS_LOW,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef CAPTURE_FILTER_EN
   localparam bit FILT_ON = 1'b1;
`else
   localparam bit FILT_ON = 1'b0;
`endif

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   sync_out;
   logic                   meas_src;
   logic                   lvl;
   logic                   rise;
   logic                   fall;

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [CNT_W-1:0]       high_reg, high_next;
   logic [CNT_W-1:0]       period_reg, period_next;
   logic                   ovf_reg, ovf_next;
   logic                   pol_reg, pol_next;
   logic                   cont_reg, cont_next;
   logic                   edge_reg, edge_next;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      end
   end

   assign sync_out = sync_reg[SYNC_STAGES-1];

   if (FILT_ON && FILT_LEN > 0) begin : g_filt
      localparam int FW = $clog2(FILT_LEN + 1);
      logic          filt_level_reg;
      logic [FW-1:0] filt_cnt_reg;

      // Level follows the input only after FILT_LEN consecutive differing samples.
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
         if (wb_rst_i) begin
            filt_level_reg <= 1'b0;
            filt_cnt_reg   <= '0;
         end else if (sync_out == filt_level_reg) begin
            filt_cnt_reg <= '0;
         end else if (filt_cnt_reg == FW'(FILT_LEN - 1)) begin
            filt_level_reg <= sync_out;
            filt_cnt_reg   <= '0;
         end else begin
            filt_cnt_reg <= filt_cnt_reg + FW'(1);
         end
      end

      assign meas_src = filt_level_reg;
   end else begin : g_nofilt
      assign meas_src = sync_out;
   end

   assign lvl  = meas_src ^ pol_reg;
   assign rise = lvl & ~edge_reg;
   assign fall = ~lvl & edge_reg;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         high_reg   <= '0;
         period_reg <= '0;
         ovf_reg    <= 1'b0;
         pol_reg    <= 1'b0;
         cont_reg   <= 1'b0;
         edge_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         high_reg   <= high_next;
         period_reg <= period_next;
         ovf_reg    <= ovf_next;
         pol_reg    <= pol_next;
         cont_reg   <= cont_next;
         edge_reg   <= edge_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      high_next   = high_reg;
      period_next = period_reg;
      ovf_next    = ovf_reg;
      pol_next    = pol_reg;
      cont_next   = cont_reg;
      edge_next   = lvl;
      case (state_reg)
         S_IDLE: begin
            if (arm) begin
               pol_next   = pol;
               cont_next  = cont;
               // Preload with the new polarity so arming never fakes an edge.
               edge_next  = meas_src ^ pol;
               state_next = S_WAIT_RISE;
            end
         end
         S_WAIT_RISE: begin
            if (rise) begin
               cnt_next   = CNT_W'(1);
               state_next = S_MEAS_HIGH;
            end
         end
         S_MEAS_HIGH: begin
            if (fall) begin
               high_next  = cnt_reg;
               // Hold at max so a late fall still saturates the period next cycle.
               cnt_next   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
               state_next = S_MEAS_LOW;
            end else if (cnt_reg == CNT_MAX) begin
               high_next   = CNT_MAX;
               period_next = CNT_MAX;
               ovf_next    = 1'b1;
               state_next  = S_DONE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_MEAS_LOW: begin
            if (rise) begin
               period_next = cnt_reg;
               ovf_next    = 1'b0;
               state_next  = S_DONE;
            end else if (cnt_reg == CNT_MAX) begin
               period_next = CNT_MAX;
               ovf_next    = 1'b1;
               state_next  = S_DONE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (res_ready) begin
               state_next = cont_reg ? S_WAIT_RISE : S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign busy       = (state_reg != S_IDLE);
   assign res_valid  = (state_reg == S_DONE);
   assign high_cnt   = high_reg;
   assign period_cnt = period_reg;
   assign overflow   = ovf_reg;

endmodule

// File: tb/tb_pulse_capture.sv
// Bench for pulse_capture: randomised pulse shapes, expected results queued and popped by a monitor on handshake.
module tb_pulse_capture;

   localparam int CNT_W = 8;
   localparam int MAXV  = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [CNT_W-1:0] h;
      logic [CNT_W-1:0] p;
      logic             o;
   } res_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             sig_in;
   logic             arm;
   logic             pol;
   logic             cont;
   logic             busy;
   logic             res_valid;
   logic             res_ready;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic             overflow;

   res_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   hold_ready = 1'b0;
   bit   ready_force = 1'b0;
   bit   pwm_run = 1'b0;

   always #5 clk = ~clk;

   pulse_capture #(.CNT_W(CNT_W)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .sig_in    (sig_in),
      .arm       (arm),
      .pol       (pol),
      .cont      (cont),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .high_cnt  (high_cnt),
      .period_cnt(period_cnt),
      .overflow  (overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Reference: a phase of h measured-high cycles then l measured-low cycles,
   // with the counters saturating at MAXV unless the edge lands on that cycle.
   function automatic res_t model(input int h, input int l);
      res_t r;
      if (h > MAXV) begin
         r.h = MAXV[CNT_W-1:0]; r.p = MAXV[CNT_W-1:0]; r.o = 1'b1;
      end else if (h + l > MAXV) begin
         r.h = h[CNT_W-1:0]; r.p = MAXV[CNT_W-1:0]; r.o = 1'b1;
      end else begin
         r.h = h[CNT_W-1:0]; r.p = 8'(h + l); r.o = 1'b0;
      end
      return r;
   endfunction

   task automatic wait_idle(input string name, input int bound);
      int n = 0;
      while (busy && n < bound) begin
         tick();
         n++;
      end
      check(name, busy, 0);
   endtask

   // One single-shot measurement; pad idles at the level that reads as "low" after pol.
   task automatic run_meas(input int h, input int l, input logic p, input bit stray);
      exp_q.push_back(model(h, l));
      sig_in = p; pol = p; cont = 1'b0;
      repeat (5) tick();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      repeat (4) tick();
      sig_in = ~p;
      if (stray) begin
         arm = 1'b1;
         pol = ~p;
      end
      tick();
      arm = 1'b0;
      pol = p;
      repeat (h - 1) tick();
      sig_in = p;
      repeat (l) tick();
      sig_in = ~p;
      repeat (8) tick();
      sig_in = p;
      wait_idle("idle_after_meas", 3000);
      $display("meas h=%0d l=%0d pol=%0d stray=%0d done", h, l, p, stray);
   endtask

   // Consumer: random ready unless the stimulus takes control.
   initial begin
      res_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         res_ready = hold_ready ? ready_force : ($urandom_range(0, 3) != 0);
      end
   end

   // Continuous PWM source, 3 high / 7 low.
   initial begin
      forever begin
         if (pwm_run) begin
            sig_in = 1'b1;
            repeat (3) tick();
            sig_in = 1'b0;
            repeat (7) tick();
         end else begin
            tick();
         end
      end
   end

   // Monitor: every presented result must match the queue head; pop on handshake.
   initial begin
      res_t act;
      forever begin
         @(negedge clk);
         if (!rst && res_valid) begin
            checks++;
            act = {high_cnt, period_cnt, overflow};
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result: got high=%0d period=%0d ovf=%0d, required no result",
                        high_cnt, period_cnt, overflow);
            end else begin
               if (act !== exp_q[0]) begin
                  errors++;
                  $display("FAIL result: got high=%0d period=%0d ovf=%0d, required high=%0d period=%0d ovf=%0d",
                           act.h, act.p, act.o, exp_q[0].h, exp_q[0].p, exp_q[0].o);
               end
               if (res_ready) begin
                  $display("result high=%0d period=%0d ovf=%0d accepted", act.h, act.p, act.o);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst = 1'b1; sig_in = 1'b0; arm = 1'b0; pol = 1'b0; cont = 1'b0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_valid", res_valid, 0);
      check("rst_high", high_cnt, 0);
      check("rst_period", period_cnt, 0);
      check("rst_ovf", overflow, 0);
      rst = 1'b0;
      tick();

      run_meas(3, 7, 1'b0, 1'b0);
      run_meas(7, 3, 1'b1, 1'b0);
      run_meas(1, 1, 1'b0, 1'b0);
      run_meas(1, 1, 1'b1, 1'b1);
      run_meas(300, 5, 1'b0, 1'b0);
      run_meas(255, 5, 1'b0, 1'b0);
      run_meas(254, 1, 1'b0, 1'b0);
      run_meas(5, 250, 1'b0, 1'b0);
      run_meas(5, 260, 1'b1, 1'b0);

      for (int i = 0; i < 20; i++) begin
         run_meas(int'($urandom_range(1, 40)), int'($urandom_range(1, 40)),
                  1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end

      // Continuous mode with a stalled consumer.
      sig_in = 1'b0; pol = 1'b0; cont = 1'b1;
      hold_ready = 1'b1; ready_force = 1'b0;
      repeat (5) tick();
      arm = 1'b1;
      tick();
      arm = 1'b0; cont = 1'b0;
      for (int k = 0; k < 3; k++) exp_q.push_back(model(3, 7));
      pwm_run = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (!res_valid && n < 300) begin
            tick();
            n++;
         end
         check("cont_valid", res_valid, 1);
         repeat (40) tick();
         check("cont_hold_valid", res_valid, 1);
         check("cont_hold_busy", busy, 1);
         ready_force = 1'b1;
         tick();
         ready_force = 1'b0;
         repeat (3) tick();
         check("cont_valid_drop", res_valid, 0);
         check("cont_busy_after_accept", busy, 1);
      end

      // Reset in the low phase of a fresh measurement.
      n = 0;
      while (sig_in !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      while (sig_in !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      check("pwm_fall_seen", sig_in, 0);
      repeat (5) tick();
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_valid", res_valid, 0);
      check("midrst_high", high_cnt, 0);
      check("midrst_period", period_cnt, 0);
      check("midrst_ovf", overflow, 0);
      $display("reset during measurement applied");
      pwm_run = 1'b0;
      hold_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      repeat (12) tick();

      run_meas(3, 7, 1'b0, 1'b0);

      repeat (5) tick();
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
